// File: rtl/implies_rr_arbiter.sv
// implies_rr_arbiter
// Two-requester round-robin arbiter that shares one bitwise implication unit
// (Y = ~A | B). The result is held in a one-entry output register that uses
// a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/a/b/ready  requester N handshake and operand pair (N = 0, 1);
//                         reqN_ready is combinational (the grant)
//   rsp_valid/data/id     registered result, its source requester, and valid
//   rsp_ready             consumer accepts the held result this cycle
//   gnt_cnt0, gnt_cnt1    saturating grant counters, present only when
//                         IMPLIES_ARB_STATS_EN is defined
//
// Configuration macro: IMPLIES_ARB_STATS_EN (grant statistics counters).
module implies_rr_arbiter #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  input  logic              rsp_ready
`ifdef IMPLIES_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Bitwise implication; each bit is independent, so there are no carries.
  function automatic logic [DATA_W-1:0] implies_f(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return ~a | b;
  endfunction

  state_t              state_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_id_r;
  logic                last_gnt_r;
  logic                can_accept_s;
  logic                gnt0_s;
  logic                gnt1_s;

  // Grant selection: the output slot is free or drains this cycle. On
  // contention the requester that did not win last time is granted. The
  // grants are gated by rst_n so that no ready is asserted during reset.
  always_comb begin
    can_accept_s = (state_r == EMPTY) || rsp_ready;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    if (can_accept_s && rst_n) begin
      if (req0_valid && req1_valid) begin
        if (last_gnt_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else if (req0_valid) begin
        gnt0_s = 1'b1;
      end else if (req1_valid) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // Output-register FSM. A new grant takes priority over a plain drain, so
  // drain and refill happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_id_r    <= 1'b0;
      last_gnt_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY, FULL: begin
          if (gnt0_s) begin
            state_r     <= FULL;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= implies_f(req0_a, req0_b);
            rsp_id_r    <= 1'b0;
            last_gnt_r  <= 1'b0;
          end else if (gnt1_s) begin
            state_r     <= FULL;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= implies_f(req1_a, req1_b);
            rsp_id_r    <= 1'b1;
            last_gnt_r  <= 1'b1;
          end else if ((state_r == FULL) && rsp_ready) begin
            state_r     <= EMPTY;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r     <= state_r;
            rsp_valid_r <= rsp_valid_r;
          end
        end
        default: begin
          state_r     <= EMPTY;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;

`ifdef IMPLIES_ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0_r;
  logic [CNT_W-1:0] gnt_cnt1_r;

  // Saturating per-requester handshake counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_r <= {CNT_W{1'b0}};
      gnt_cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (gnt0_s && (gnt_cnt0_r != {CNT_W{1'b1}})) begin
        gnt_cnt0_r <= gnt_cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        gnt_cnt0_r <= gnt_cnt0_r;
      end
      if (gnt1_s && (gnt_cnt1_r != {CNT_W{1'b1}})) begin
        gnt_cnt1_r <= gnt_cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        gnt_cnt1_r <= gnt_cnt1_r;
      end
    end
  end

  assign gnt_cnt0 = gnt_cnt0_r;
  assign gnt_cnt1 = gnt_cnt1_r;
`endif

endmodule

// File: tb/tb_implies_rr_arbiter.sv
// Self-checking bench for implies_rr_arbiter: a queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_implies_rr_arbiter;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              req0_ready, req1_ready;
  logic              rsp_valid, rsp_id, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
`ifdef IMPLIES_ARB_STATS_EN
  logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;
`endif

  implies_rr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready)
`ifdef IMPLIES_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the result slot is a queue of at most one entry; the
  // last held value is remembered separately because it persists when empty.
  typedef struct packed { logic id; logic [DATA_W-1:0] data; } rsp_t;
  rsp_t slot_q[$];
  rsp_t held;
  int   last_winner;
  int   m_cnt[2];
  int   exp_winner;   // -1 means no grant predicted this cycle

  function automatic int pick_winner(input logic v0, input logic v1, input int last);
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Compare process: predict the grant from the current inputs and check all
  // outputs against the model on the falling edge.
  always @(negedge clk) begin : cmp
    int w;
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      chk("rst_valid", rsp_valid, 1'b0);
      exp_winner <= -1;
    end else begin
      w = -1;
      if (slot_q.size() == 0 || rsp_ready) w = pick_winner(req0_valid, req1_valid, last_winner);
      exp_winner <= w;
      chk("m_ready0", req0_ready, (w == 0));
      chk("m_ready1", req1_ready, (w == 1));
      chk("m_valid", rsp_valid, (slot_q.size() != 0));
      chk("m_data", rsp_data, held.data);
      chk("m_id", rsp_id, held.id);
`ifdef IMPLIES_ARB_STATS_EN
      chk("m_cnt0", gnt_cnt0, m_cnt[0]);
      chk("m_cnt1", gnt_cnt1, m_cnt[1]);
`endif
    end
  end

  // Model update on the rising edge using the grant predicted above.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q.delete();
      held        <= '0;
      last_winner <= 1;
      m_cnt[0]    <= 0;
      m_cnt[1]    <= 0;
    end else begin
      if (slot_q.size() != 0 && rsp_ready) slot_q.pop_front();
      if (exp_winner >= 0) begin
        rsp_t r;
        r.id   = exp_winner[0];
        r.data = (exp_winner == 0) ? (~req0_a | req0_b) : (~req1_a | req1_b);
        slot_q.push_back(r);
        held        <= r;
        last_winner <= exp_winner;
        if (m_cnt[exp_winner] < 255) m_cnt[exp_winner] <= m_cnt[exp_winner] + 1;
      end
    end
  end

  task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                       input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] id_seq;
    rst_n = 1'b0;
    drive(1'b1, 4'b1010, 4'b0100, 1'b1, 4'b1111, 4'b0011, 1'b1);
    repeat (3) step();
    // Reset state with both requesters valid.
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_data", rsp_data, 4'b0000);
    chk("reset_id", rsp_id, 1'b0);
    chk("reset_ready0", req0_ready, 1'b0);
    chk("reset_ready1", req1_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("release_ready0", req0_ready, 1'b1);
    chk("release_ready1", req1_ready, 1'b0);

    // Contention: six grants alternate starting with requester 0.
    id_seq = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cont_valid", rsp_valid, 1'b1);
      chk("cont_id", rsp_id, (i % 2 == 1));
      chk("cont_data", rsp_data, (i % 2 == 1) ? 4'b0011 : 4'b0101);
    end

    // Backpressure: hold id 1 / 0011 for three cycles with both readies low.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready0", req0_ready, 1'b0);
      chk("bp_ready1", req1_ready, 1'b0);
      step();
      chk("bp_data", rsp_data, 4'b0011);
      chk("bp_id", rsp_id, 1'b1);
      chk("bp_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("drain_ready0", req0_ready, 1'b1);
    step();
    chk("drain_id", rsp_id, 1'b0);
    chk("drain_valid", rsp_valid, 1'b1);

    // Single requester 1 right after requester 0 won, then idle drain.
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0110, 4'b1000, 1'b1);
    step();
    chk("single1_id", rsp_id, 1'b1);
    chk("single1_data", rsp_data, 4'b1001);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    step();
    chk("idle_valid", rsp_valid, 1'b0);
    chk("idle_data_held", rsp_data, 4'b1001);

    // Single request from requester 0.
    drive(1'b1, 4'b1010, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b1);
    step();
    chk("single0_valid", rsp_valid, 1'b1);
    chk("single0_data", rsp_data, 4'b0101);
    chk("single0_id", rsp_id, 1'b0);

    // Mid-operation reset while FULL and stalled.
    drive(1'b1, 4'b1010, 4'b0100, 1'b1, 4'b1111, 4'b0011, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 1'b0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("midrst_ready0", req0_ready, 1'b1);
    chk("midrst_ready1", req1_ready, 1'b0);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      step();
      drive($urandom_range(0, 1), 4'($urandom), 4'($urandom),
            $urandom_range(0, 1), 4'($urandom), 4'($urandom), $urandom_range(0, 1));
    end

`ifdef IMPLIES_ARB_STATS_EN
    // Counter saturation after 300 requester 0 handshakes.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b1, 4'b0011, 4'b0101, 1'b0, 4'b0000, 4'b0000, 1'b1);
    repeat (300) step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    step();
    chk("stats_cnt0", gnt_cnt0, 8'd255);
    chk("stats_cnt1", gnt_cnt1, 8'd0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
